// File: rtl/noc_pkg.sv
// Shared router definitions: port count and indices, arbiter states,
// and small index helpers used by the per-output arbiters.
package noc_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] N     = 3'd1;
  localparam logic [2:0] E     = 3'd2;
  localparam logic [2:0] S     = 3'd3;
  localparam logic [2:0] W     = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Port index + 1, wrapping 4 -> 0.
  function automatic logic [2:0] inc_mod5(input logic [2:0] x);
    if (x >= 3'd4) return 3'd0;
    return x + 3'd1;
  endfunction

  // One-hot grant row for a port index.
  function automatic logic [NPORTS-1:0] onehot5(input logic [2:0] x);
    return NPORTS'(1) << x;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Round-robin picker: first requester after ptr, searching ptr+1, ptr+2, ...
// modulo 5. Purely combinational so every output arbiter can share it.
module rr_pick5
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [2:0]        ptr,
  output logic              found,
  output logic [2:0]        idx
);

  logic [2:0] cand;

  // Walk the five candidates in priority order and keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    cand  = ptr;
    for (int k = 0; k < NPORTS; k++) begin
      cand = inc_mod5(cand);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/out_arbiter4.sv
// Wormhole round-robin switch arbiter for router output 4.
//
// state  | meaning
// IDLE   | no owner, all grants low; arbitrates when credits are available
// LOCKED | one input owns output 4 from header through tail flit
module out_arbiter4
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORTS-1:0]   req,
  input  logic [NPORTS-1:0]   tail,
  input  logic                credit_in,
  output logic                g40,
  output logic                g41,
  output logic                g42,
  output logic                g43,
  output logic                g44,
  output logic                xfer,
  output logic [CW-1:0]       credits,
  output logic                err_credit
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  arb_state_e          state_q, state_d;
  logic [2:0]          own_q, own_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [NPORTS-1:0]   grant_q, grant_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic                err_q, err_d;

  logic                pick_found;
  logic [2:0]          pick_idx;
  logic                has_credit;
  logic                xfer_w;

  rr_pick5 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign has_credit = (credits_q != '0);
  // A flit moves only while locked, the owner presents one and downstream has room.
  assign xfer_w     = (state_q == LOCKED) && req[own_q] && has_credit;

  // Next-state logic: arbitration in IDLE, release on the owner's tail flit.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found && has_credit) begin
          state_d = LOCKED;
          own_d   = pick_idx;
          ptr_d   = pick_idx;
          grant_d = onehot5(pick_idx);
        end
      end
      LOCKED: begin
        if (xfer_w && tail[own_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Credit counter: simultaneous take and return cancel; a return at full
  // saturates and latches the overflow flag until reset.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    unique case ({credit_in, xfer_w})
      2'b10: begin
        if (credits_q == FULL) err_d = 1'b1;
        else                   credits_d = credits_q + CW'(1);
      end
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  // State, ownership, grant row and credit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      own_q     <= 3'd0;
      ptr_q     <= W;
      grant_q   <= '0;
      credits_q <= FULL;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign g40        = grant_q[LOCAL];
  assign g41        = grant_q[N];
  assign g42        = grant_q[E];
  assign g43        = grant_q[S];
  assign g44        = grant_q[W];
  assign xfer       = xfer_w;
  assign credits    = credits_q;
  assign err_credit = err_q;

endmodule

// File: tb/tb_out_arbiter4.sv
// Directed bench for out_arbiter4: a per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_out_arbiter4;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_in;
  logic       g40, g41, g42, g43, g44;
  logic       xfer;
  logic [2:0] credits;
  logic       err_credit;

  int n_total;
  int n_pass;

  typedef struct {
    logic [4:0] req;
    logic [4:0] tail;
    logic       ci;
    logic [4:0] eg;
    logic       ex;
    logic [2:0] ec;
    logic       ee;
  } vec_t;

  vec_t vecs[$];

  out_arbiter4 #(.BUF_DEPTH(4), .CW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .g40        (g40),
    .g41        (g41),
    .g42        (g42),
    .g43        (g43),
    .g44        (g44),
    .xfer       (xfer),
    .credits    (credits),
    .err_credit (err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic [4:0] r, input logic [4:0] t, input logic ci,
                             input logic [4:0] g, input logic x, input logic [2:0] c,
                             input logic e);
    vec_t o;
    o.req = r; o.tail = t; o.ci = ci;
    o.eg = g; o.ex = x; o.ec = c; o.ee = e;
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [4:0] eg, input logic ex,
                           input logic [2:0] ec, input logic ee);
    check({tag, " grant"},      int'({g44, g43, g42, g41, g40}), int'(eg));
    check({tag, " xfer"},       int'(xfer),       int'(ex));
    check({tag, " credits"},    int'(credits),    int'(ec));
    check({tag, " err_credit"}, int'(err_credit), int'(ee));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // Single request after reset.
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00000, 0, 3'd4, 0)); // 0
    vecs.push_back(v(5'b00100, 5'b00100, 0, 5'b00100, 1, 3'd4, 0)); // 1
    vecs.push_back(v(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd3, 0)); // 2
    vecs.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd3, 0)); // 3
    // Three-flit packet from 1 while 3 waits; xfer+credit in cycle 6.
    vecs.push_back(v(5'b00010, 5'b00000, 0, 5'b00000, 0, 3'd4, 0)); // 4
    vecs.push_back(v(5'b01010, 5'b00000, 0, 5'b00010, 1, 3'd4, 0)); // 5
    vecs.push_back(v(5'b01010, 5'b00000, 1, 5'b00010, 1, 3'd3, 0)); // 6
    vecs.push_back(v(5'b01010, 5'b00010, 0, 5'b00010, 1, 3'd3, 0)); // 7
    vecs.push_back(v(5'b01000, 5'b00000, 0, 5'b00000, 0, 3'd2, 0)); // 8
    vecs.push_back(v(5'b01000, 5'b01000, 1, 5'b01000, 1, 3'd2, 0)); // 9
    // Refill then overflow at full.
    vecs.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd2, 0)); // 10
    vecs.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd3, 0)); // 11
    vecs.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd4, 0)); // 12
    vecs.push_back(v(5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd4, 1)); // 13
    // Input 4 single flit sets ptr=4; then wrap 0 -> 4 -> 0.
    vecs.push_back(v(5'b10000, 5'b00000, 0, 5'b00000, 0, 3'd4, 1)); // 14
    vecs.push_back(v(5'b10000, 5'b10000, 0, 5'b10000, 1, 3'd4, 1)); // 15
    vecs.push_back(v(5'b10001, 5'b00000, 0, 5'b00000, 0, 3'd3, 1)); // 16
    vecs.push_back(v(5'b10001, 5'b00001, 0, 5'b00001, 1, 3'd3, 1)); // 17
    vecs.push_back(v(5'b10001, 5'b00000, 0, 5'b00000, 0, 3'd2, 1)); // 18
    vecs.push_back(v(5'b10001, 5'b10000, 0, 5'b10000, 1, 3'd2, 1)); // 19
    vecs.push_back(v(5'b10001, 5'b00000, 1, 5'b00000, 0, 3'd1, 1)); // 20
    vecs.push_back(v(5'b00001, 5'b00001, 1, 5'b00001, 1, 3'd2, 1)); // 21
    vecs.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd2, 1)); // 22
    vecs.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd3, 1)); // 23
    // Six-flit packet from 2 with a bubble and credit exhaustion.
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00000, 0, 3'd4, 1)); // 24
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00100, 1, 3'd4, 1)); // 25
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00100, 1, 3'd3, 1)); // 26
    vecs.push_back(v(5'b00010, 5'b00000, 0, 5'b00100, 0, 3'd2, 1)); // 27
    vecs.push_back(v(5'b00110, 5'b00000, 0, 5'b00100, 1, 3'd2, 1)); // 28
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00100, 1, 3'd1, 1)); // 29
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00100, 0, 3'd0, 1)); // 30
    vecs.push_back(v(5'b00100, 5'b00000, 1, 5'b00100, 0, 3'd0, 1)); // 31
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00100, 1, 3'd1, 1)); // 32
    vecs.push_back(v(5'b00100, 5'b00000, 0, 5'b00100, 0, 3'd0, 1)); // 33
    vecs.push_back(v(5'b00100, 5'b00100, 1, 5'b00100, 0, 3'd0, 1)); // 34
    vecs.push_back(v(5'b00100, 5'b00100, 0, 5'b00100, 1, 3'd1, 1)); // 35
    // No arbitration while credits are zero.
    vecs.push_back(v(5'b00010, 5'b00000, 0, 5'b00000, 0, 3'd0, 1)); // 36
    vecs.push_back(v(5'b00010, 5'b00000, 1, 5'b00000, 0, 3'd0, 1)); // 37
    vecs.push_back(v(5'b00010, 5'b00000, 0, 5'b00000, 0, 3'd1, 1)); // 38
    vecs.push_back(v(5'b00010, 5'b00000, 0, 5'b00010, 1, 3'd1, 1)); // 39

    rst       = 1'b0;
    req       = '0;
    tail      = '0;
    credit_in = 1'b0;
    #12;
    check_all("reset", 5'b00000, 1'b0, 3'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      req       = vecs[i].req;
      tail      = vecs[i].tail;
      credit_in = vecs[i].ci;
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ex, vecs[i].ec, vecs[i].ee);
    end

    // Mid-packet reset: input 1 locked with no credits left.
    @(posedge clk);
    #1;
    credit_in = 1'b0;
    check_all("pre_reset", 5'b00010, 1'b0, 3'd0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_reset", 5'b00000, 1'b0, 3'd4, 1'b0);
    @(negedge clk);
    rst  = 1'b1;
    req  = 5'b11111;
    tail = 5'b00001;
    @(negedge clk);
    check_all("restart", 5'b00001, 1'b1, 3'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/out_arbiter4.md
# out_arbiter4

Wormhole round-robin switch arbiter for router output port 4. It takes per-input requests, header/tail markers and downstream credit returns, and produces the one-hot grant row g40..g44 that drives the output-4 selector and crossbar mux. A grant is held from the header flit through the tail flit. Flits are issued only while downstream credits are nonzero.

## Interface
Parameters:
- BUF_DEPTH, 4: downstream input-buffer depth in flits; reset credit count.
- CW, 3: credit counter width; must satisfy 2^CW > BUF_DEPTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  5  req[i]: input port i has a flit for output 4.
- tail  input  5  tail[i]: the flit currently at input i is a tail flit. A single-flit packet has both header and tail set.
- credit_in  input  1  one-cycle pulse; downstream freed one buffer slot.
- g40, g41, g42, g43, g44  output  1 each  registered grant, at most one high.
- xfer  output  1  combinational; a flit moves through output 4 this cycle.
- credits  output  CW  current credit count.
- err_credit  output  1  sticky credit-overflow flag.

## Operation
- States:
  - IDLE: all grants 0.
  - LOCKED: exactly one grant high, for owner index own.
- Last-winner pointer ptr ranges 0..4. Search order is ptr+1, ptr+2, … modulo 5, wrapping 4→0.
- Transitions out of IDLE:
  - If any req is set and credits != 0: pick the first requester in search order, set own and ptr to it, and go to LOCKED.
  - If credits == 0: stay in IDLE even with requests pending.
- Behaviour in LOCKED:
  - xfer = req[own] && credits != 0.
  - If xfer && tail[own]: go to IDLE next cycle.
  - If req[own] is low, hold the lock. Requests from other inputs are ignored.
- Credits:
  - Decrement by 1 on xfer; increment by 1 on credit_in.
  - Both in the same cycle: no change.
  - credit_in with credits == BUF_DEPTH and no xfer: saturate at BUF_DEPTH and set err_credit. err_credit is cleared only by reset.
- xfer is never asserted in IDLE.
- Reset values:
  - state = IDLE; g40..g44 = 0; xfer = 0.
  - credits = BUF_DEPTH; ptr = 4, so input 0 has first priority; err_credit = 0.

## Timing
- Request to grant: req sampled at edge N gives a grant visible after edge N+1. The first xfer is possible in cycle N+1.
- Once locked, throughput is one flit per cycle while req[own] is high and credits are nonzero.
- Tail to release:
  - xfer with tail in cycle M deasserts the grant after edge M+1.
  - The next grant appears after edge M+2, so there is one idle cycle between packets.
- credits updates at the edge following xfer or credit_in. A credit returned in cycle K permits xfer in cycle K+1.
- Reset asserted mid-packet clears the lock and all grants immediately (asynchronous) and restores BUF_DEPTH credits. Any partial packet is lost; upstream must also be reset.
- Grants are registered, so the downstream selector sees glitch-free one-hot inputs. An all-zero grant row is the IDLE encoding.

## Structure
- Shared package `noc_pkg`:
  - NPORTS = 5.
  - Port index constants: LOCAL = 0, N = 1, E = 2, S = 3, W = 4.
  - Arbiter state enum {IDLE, LOCKED}.
  - The modulo-5 increment function.
- One combinational sub-module `rr_pick5`:
  - Inputs: req[4:0] and ptr.
  - Outputs: found and idx[2:0].
  - Reused by the arbiters for output ports 0–3.
- The state register, own/ptr registers and credit counter live in out_arbiter4.

## Test plan
- **Reset, then single request.** After reset, req = 5'b00100. Required: g42 goes high one cycle later; credits = 4; ptr becomes 2.
- **Three-flit packet with contention.** Input 1 sends a 3-flit packet (tail on the third flit) while req[3] is held high throughout. Required: g41 is held for exactly 3 xfers; all grants are 0 for one cycle; then g43 is granted.
- **Round-robin wrap.** ptr = 4 and req = 5'b10001. Required: input 0 wins. After its tail, input 4 wins; after that tail, input 0 wins again.
- **Credit exhaustion.** BUF_DEPTH = 4, no credit_in, a 6-flit packet. Required: xfer occurs 4 times, then stalls with the grant held and credits = 0. One credit_in pulse allows exactly one more xfer in the following cycle.
- **Simultaneous events and overflow.** xfer and credit_in in the same cycle: credits unchanged. At credits = 4 with no xfer, a credit_in pulse: credits stays 4 and err_credit rises and stays high.
- **Mid-packet reset.** Drop rst mid-packet. Required: grants are 0 immediately; credits = 4; after release, arbitration restarts from input 0.
